// File: rtl/multi_tick.sv
// Multi-channel delayed-start pulse generator: per-channel button -> programmable delay -> one-cycle start pulse.
// Optional build macro MULTI_TICK_ABORT_EN: releasing the button during COUNT cancels the pending pulse.
module multi_tick #(
    parameter int unsigned Channels = 4,
    parameter int unsigned Width    = 30
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    k_i,
    input  logic [Channels-1:0] mode_i,
    input  logic [Channels-1:0] button_i,
    output logic [Channels-1:0] start_o,
    output logic [Channels-1:0] busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // A requested delay of zero behaves exactly like a delay of one
    logic [Width-1:0] k_eff_c;
    assign k_eff_c = (k_i == '0) ? Width'(1) : k_i;

    for (genvar c = 0; c < Channels; c++) begin : g_ch
        state_t           state;
        state_t           state_nx;
        logic [Width-1:0] cnt;
        logic [Width-1:0] cnt_nx;
        logic [Width-1:0] kq;
        logic [Width-1:0] kq_nx;
        logic             start_q;
        logic             busy_q;

        // Outputs are flopped from the next state so they line up with the state register
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state   <= IDLE;
                cnt     <= '0;
                kq      <= '0;
                start_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state   <= state_nx;
                cnt     <= cnt_nx;
                kq      <= kq_nx;
                start_q <= (state_nx == FIRE);
                busy_q  <= (state_nx != IDLE);
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            kq_nx    = kq;
            unique case (state)
                IDLE: begin
                    if (button_i[c]) begin
                        state_nx = COUNT;
                        cnt_nx   = Width'(1);
                        kq_nx    = k_eff_c;
                    end
                end
                COUNT: begin
`ifdef MULTI_TICK_ABORT_EN
                    if (!button_i[c]) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else
`endif
                    if (cnt == kq) begin
                        state_nx = FIRE;
                    end else begin
                        cnt_nx = cnt + Width'(1);
                    end
                end
                FIRE: begin
                    // Mode is only consulted here, so a mid-count mode change waits for this point
                    if (mode_i[c] && button_i[c]) begin
                        state_nx = COUNT;
                        cnt_nx   = Width'(1);
                        kq_nx    = k_eff_c;
                    end else if (button_i[c]) begin
                        state_nx = HOLD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                HOLD: begin
                    if (!button_i[c]) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        assign start_o[c] = start_q;
        assign busy_o[c]  = busy_q;
    end

endmodule

// File: tb/tb_multi_tick.sv
// Self-checking bench for multi_tick: timestamp-based reference model, directed scenarios and random traffic.
module tb_multi_tick;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 30;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [W-1:0]  k_i;
    logic [CH-1:0] mode_i;
    logic [CH-1:0] button_i;
    logic [CH-1:0] start_o;
    logic [CH-1:0] busy_o;

    multi_tick #(.Channels(CH), .Width(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .k_i      (k_i),
        .mode_i   (mode_i),
        .button_i (button_i),
        .start_o  (start_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: a channel is waiting for an absolute edge number, firing, held, or idle
    longint edge_no = 0;
    longint fire_at [CH];
    bit     pending [CH];
    bit     holding [CH];
    bit     firing  [CH];

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            pending[c] = 1'b0;
            holding[c] = 1'b0;
            firing[c]  = 1'b0;
            fire_at[c] = 0;
        end
    endtask

    task automatic model_edge();
        longint kk;
        edge_no++;
        kk = (k_i == '0) ? 64'd1 : longint'(k_i);
        for (int c = 0; c < CH; c++) begin
            if (rst_i) begin
                pending[c] = 1'b0;
                holding[c] = 1'b0;
                firing[c]  = 1'b0;
            end else if (firing[c]) begin
                firing[c] = 1'b0;
                if (mode_i[c] && button_i[c]) begin
                    pending[c] = 1'b1;
                    fire_at[c] = edge_no + kk;
                end else if (button_i[c]) begin
                    holding[c] = 1'b1;
                end
            end else if (holding[c]) begin
                if (!button_i[c]) holding[c] = 1'b0;
            end else if (pending[c]) begin
`ifdef MULTI_TICK_ABORT_EN
                if (!button_i[c]) pending[c] = 1'b0; else
`endif
                if (edge_no == fire_at[c]) begin
                    pending[c] = 1'b0;
                    firing[c]  = 1'b1;
                end
            end else if (button_i[c]) begin
                pending[c] = 1'b1;
                fire_at[c] = edge_no + kk;
            end
        end
    endtask

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance model on the edge, compare both outputs just after it
    task automatic step();
        logic [CH-1:0] es;
        logic [CH-1:0] eb;
        @(posedge clk_i);
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            es[c] = firing[c];
            eb[c] = pending[c] | holding[c] | firing[c];
        end
        check("start_o", start_o, es);
        check("busy_o", busy_o, eb);
    endtask

    task automatic idle_out(input int n);
        button_i = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Button on channel ch held for n_hold edges from E0; k may change after E0
    task automatic run_seq(input int ch, input int k0, input int k1, input int n_hold,
                           input int n_total, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        k_i    = W'(k0);
        for (int i = 0; i < n_total; i++) begin
            button_i[ch] = (i < n_hold);
            step();
            if (i == 0) k_i = W'(k1);
            if (start_o[ch]) begin
                if (first < 0) first = i;
                pulses++;
            end
        end
        button_i[ch] = 1'b0;
    endtask

    initial begin
        int p;
        int f;
        rst_i    = 1'b1;
        k_i      = W'(5);
        mode_i   = '0;
        button_i = '0;
        model_clear();
        #1;
        check("reset_start", start_o, '0);
        check("reset_busy", busy_o, '0);
        repeat (2) step();
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset mid-count: k=10, five counts in, then async reset
        k_i = W'(10);
        button_i[0] = 1'b1;
        step();
        button_i[0] = 1'b0;
        repeat (4) step();
        #2;
        rst_i = 1'b1;
        #1;
        model_clear();
        check("async_rst_start", start_o, '0);
        check("async_rst_busy", busy_o, '0);
        step();
        @(negedge clk_i);
        rst_i = 1'b0;
        run_seq(0, 10, 10, 0, 15, p, f);
        check_int("no_pulse_after_rst", p, 0);

        // One-shot latency, held 20 cycles
        mode_i = '0;
        run_seq(0, 5, 5, 20, 25, p, f);
        check_int("oneshot_pulses", p, 1);
        check_int("oneshot_latency", f, 5);

        // Auto-repeat on channel 1, k=3
        mode_i = 4'b0010;
        run_seq(1, 3, 3, 20, 30, p, f);
        check_int("repeat_pulses", p, 5);
        check_int("repeat_first", f, 3);
        mode_i = '0;

        // k boundaries and mid-count k change
        run_seq(2, 0, 0, 1, 6, p, f);
        check_int("k0_latency", f, 1);
        run_seq(2, 1, 1, 1, 6, p, f);
        check_int("k1_latency", f, 1);
        run_seq(3, 5, 2, 20, 25, p, f);
        check_int("k_change_latency", f, 5);

        // One-cycle press with k=8
        run_seq(0, 8, 8, 1, 14, p, f);
`ifdef MULTI_TICK_ABORT_EN
        check_int("abort_pulses", p, 0);
`else
        check_int("press_pulses", p, 1);
        check_int("press_latency", f, 8);
`endif

        // Staggered requests with mixed modes
        k_i    = W'(4);
        mode_i = 4'b1010;
        for (int i = 0; i < CH; i++) begin
            button_i[i] = 1'b1;
            step();
        end
        repeat (16) step();
        idle_out(10);
        mode_i = '0;

        // Largest legal k: count starts and stays busy
        k_i = '1;
        button_i[1] = 1'b1;
        repeat (40) step();
        #2;
        rst_i = 1'b1;
        #1;
        model_clear();
        check("maxk_rst_busy", busy_o, '0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        button_i = '0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) k_i = W'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) mode_i = CH'($urandom);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) button_i[c] = ~button_i[c];
            if ($urandom_range(0, 499) == 0) begin
                rst_i = 1'b1;
                step();
                rst_i = 1'b0;
            end else begin
                step();
            end
        end
        idle_out(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
